// File: rtl/riscv_muldiv_unit_pkg.sv
// Shared RV32M definitions: funct3/funct7 decode constants, FSM states and
// operand-signedness helpers used by the multiply/divide unit.
package riscv_muldiv_unit_pkg;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    // R-type funct7 that steers an ALU op to the multiply/divide unit.
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
    function automatic logic signed_a(input logic [2:0] f);
        return (f == FUNCT3_MULH) || (f == FUNCT3_MULHSU) ||
               (f == FUNCT3_DIV)  || (f == FUNCT3_REM);
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM.
    function automatic logic signed_b(input logic [2:0] f);
        return (f == FUNCT3_MULH) || (f == FUNCT3_DIV) || (f == FUNCT3_REM);
    endfunction

endpackage

// File: rtl/riscv_muldiv_unit_if.sv
// Request/response bundle between the datapath control and the muldiv unit.
interface riscv_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] op_a_i;
    logic [XLEN-1:0] op_b_i;
    logic            kill_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, funct3_i, op_a_i, op_b_i, kill_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, funct3_i, op_a_i, op_b_i, kill_i,
        output busy_o, done_o, result_o
    );
endinterface

// File: rtl/riscv_muldiv_unit_step.sv
// One radix-2 iteration on the shared 2*XLEN accumulator.
// Multiply: acc = {partial_hi, multiplier_remaining}, shift-add to the right.
// Divide:   acc = {remainder, dividend/quotient}, restoring shift-subtract to the left.
module riscv_muldiv_unit_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   operand_i,
    output logic [2*XLEN-1:0] acc_o
);
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] diff;

    assign hi = acc_i[2*XLEN-1:XLEN];
    assign lo = acc_i[XLEN-1:0];

    // Select between a shift-add and a trial-subtract step.
    always_comb begin
        // NOTE: every output and temporary gets a default first so no path infers a latch.
        acc_o  = acc_i;
        sum    = '0;
        rem_sh = '0;
        diff   = '0;
        if (is_div_i) begin
            rem_sh = {hi, lo[XLEN-1]};
            // The true difference is below the divisor, so XLEN bits suffice.
            diff   = rem_sh[XLEN-1:0] - operand_i;
            if (rem_sh >= {1'b0, operand_i}) begin
                acc_o = {diff, lo[XLEN-2:0], 1'b1};
            end else begin
                acc_o = {rem_sh[XLEN-1:0], lo[XLEN-2:0], 1'b0};
            end
        end else begin
            sum   = {1'b0, hi} + (lo[0] ? {1'b0, operand_i} : '0);
            acc_o = {sum, lo[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitudes are processed for XLEN
// cycles, then a single fix-up cycle restores signs and selects the result.
module riscv_muldiv_unit
    import riscv_muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             reset,
    riscv_muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [2*XLEN-1:0]   acc_step;
    logic [XLEN-1:0]     operand_q;
    logic [2:0]          funct3_q;
    logic                neg_res_q;
    logic                neg_rem_q;
    logic                busy_q;
    logic                done_q;
    logic [XLEN-1:0]     result_q;

    logic                sign_a;
    logic                sign_b;
    logic                in_is_div;
    logic                div_zero;
    logic                div_ovf;
    logic [XLEN-1:0]     mag_a;
    logic [XLEN-1:0]     mag_b;

    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo;
    logic [XLEN-1:0]     rem;
    logic [XLEN-1:0]     fix_result;

    riscv_muldiv_unit_step #(.XLEN(XLEN)) u_step (
        .is_div_i  (funct3_q[2]),
        .acc_i     (acc_q),
        .operand_i (operand_q),
        .acc_o     (acc_step)
    );

    // Decode the incoming request into operand signs, magnitudes and special cases.
    always_comb begin
        in_is_div = bus.funct3_i[2];
        sign_a    = signed_a(bus.funct3_i) & bus.op_a_i[XLEN-1];
        sign_b    = signed_b(bus.funct3_i) & bus.op_b_i[XLEN-1];
        mag_a     = sign_a ? -bus.op_a_i : bus.op_a_i;
        mag_b     = sign_b ? -bus.op_b_i : bus.op_b_i;
        div_zero  = in_is_div && (bus.op_b_i == '0);
        div_ovf   = ((bus.funct3_i == FUNCT3_DIV) || (bus.funct3_i == FUNCT3_REM)) &&
                    (bus.op_a_i == MIN_NEG) && (bus.op_b_i == '1);
    end

    // Sign correction and result selection applied in the fix-up cycle.
    always_comb begin
        prod       = neg_res_q ? -acc_q : acc_q;
        quo        = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem        = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        fix_result = '0;
        case (funct3_q)
            FUNCT3_MUL:    fix_result = prod[XLEN-1:0];
            FUNCT3_MULH:   fix_result = prod[2*XLEN-1:XLEN];
            FUNCT3_MULHSU: fix_result = prod[2*XLEN-1:XLEN];
            FUNCT3_MULHU:  fix_result = prod[2*XLEN-1:XLEN];
            FUNCT3_DIV:    fix_result = quo;
            FUNCT3_DIVU:   fix_result = quo;
            FUNCT3_REM:    fix_result = rem;
            FUNCT3_REMU:   fix_result = rem;
        endcase
    end

    // Control FSM with registered busy/done/result; reset outranks kill and start.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            operand_q <= '0;
            funct3_q  <= FUNCT3_MUL;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_i && !bus.kill_i) begin
                        funct3_q <= bus.funct3_i;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        if (div_zero) begin
                            // Quotient all-ones, remainder is the dividend.
                            acc_q     <= {bus.op_a_i, {XLEN{1'b1}}};
                            neg_res_q <= 1'b0;
                            neg_rem_q <= 1'b0;
                            state_q   <= ST_FIX;
                        end else if (div_ovf) begin
                            // Quotient is the dividend, remainder zero.
                            acc_q     <= {{XLEN{1'b0}}, bus.op_a_i};
                            neg_res_q <= 1'b0;
                            neg_rem_q <= 1'b0;
                            state_q   <= ST_FIX;
                        end else begin
                            acc_q     <= {{XLEN{1'b0}}, in_is_div ? mag_a : mag_b};
                            operand_q <= in_is_div ? mag_b : mag_a;
                            neg_res_q <= sign_a ^ sign_b;
                            neg_rem_q <= sign_a;
                            state_q   <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (bus.kill_i) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        acc_q <= acc_step;
                        if (cnt_q == CNT_W'(XLEN-1)) begin
                            state_q <= ST_FIX;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_FIX: begin
                    busy_q <= 1'b0;
                    if (bus.kill_i) begin
                        state_q <= ST_IDLE;
                    end else begin
                        result_q <= fix_result;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;
endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Self-checking bench for riscv_muldiv_unit (XLEN=32): directed vectors,
// randomized operations against a 64-bit arithmetic model, and kill/reset/
// double-start sequences.
module tb_riscv_muldiv_unit;
    import riscv_muldiv_unit_pkg::*;

    localparam int XLEN     = 32;
    localparam int LAT_NORM = XLEN + 2;
    localparam int LAT_SPEC = 2;

    typedef logic [XLEN-1:0] word_t;

    typedef struct {
        logic [2:0] f;
        word_t      a;
        word_t      b;
        word_t      exp;
        int         lat;
    } vec_t;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    riscv_muldiv_unit_if #(.XLEN(XLEN)) bus ();

    riscv_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: RV32M semantics computed with plain 64-bit arithmetic.
    function automatic word_t ref_model(input logic [2:0] f, input word_t a, input word_t b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] ub_s;
        logic        [63:0] ua;
        logic        [63:0] ub;
        logic        [63:0] p;
        logic               ovf;
        word_t              r;
        sa   = {{32{a[31]}}, a};
        sb   = {{32{b[31]}}, b};
        ua   = {32'b0, a};
        ub   = {32'b0, b};
        ub_s = ub;
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r    = '0;
        case (f)
            FUNCT3_MUL:    begin p = sa * sb;   r = p[31:0];  end
            FUNCT3_MULH:   begin p = sa * sb;   r = p[63:32]; end
            FUNCT3_MULHSU: begin p = sa * ub_s; r = p[63:32]; end
            FUNCT3_MULHU:  begin p = ua * ub;   r = p[63:32]; end
            FUNCT3_DIV: begin
                if (b == 0) r = '1;
                else if (ovf) r = a;
                else begin p = sa / sb; r = p[31:0]; end
            end
            FUNCT3_DIVU: r = (b == 0) ? '1 : a / b;
            FUNCT3_REM: begin
                if (b == 0) r = a;
                else if (ovf) r = '0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            FUNCT3_REMU: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input word_t a, input word_t b);
        logic is_div;
        logic sdiv;
        is_div = f[2];
        sdiv   = (f == FUNCT3_DIV) || (f == FUNCT3_REM);
        if (is_div && (b == 0 || (sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return LAT_SPEC;
        return LAT_NORM;
    endfunction

    function automatic word_t pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return word_t'($urandom);
        endcase
    endfunction

    // Issue one operation and wait (bounded) for done; latency counted in
    // cycles after the sampling edge, -1 on timeout. Operands are scrambled
    // right after acceptance.
    task automatic run_op(input logic [2:0] f, input word_t a, input word_t b,
                          output word_t res, output int lat, output int busy_err);
        busy_err = 0;
        lat      = -1;
        @(negedge clk);
        bus.funct3_i = f;
        bus.op_a_i   = a;
        bus.op_b_i   = b;
        bus.start_i  = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i  = 1'b0;
        bus.funct3_i = 3'($urandom);
        bus.op_a_i   = word_t'($urandom);
        bus.op_b_i   = word_t'($urandom);
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (bus.done_o) begin
                lat = k;
                if (bus.busy_o !== 1'b0) busy_err++;
                break;
            end else if (bus.busy_o !== 1'b1) begin
                busy_err++;
            end
        end
        res = bus.result_o;
    endtask

    task automatic run_and_check(input string tag, input logic [2:0] f, input word_t a,
                                 input word_t b, input word_t exp, input int exp_lat);
        word_t res;
        int    lat;
        int    berr;
        run_op(f, a, b, res, lat, berr);
        check({tag, " result"}, 64'(res), 64'(exp));
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " busy"}, 64'(berr), 64'(0));
    endtask

    initial begin
        vec_t  vecs[$];
        word_t a;
        word_t b;
        logic [2:0] f;
        int    dones;
        n_pass  = 0;
        n_total = 0;

        bus.start_i  = 1'b0;
        bus.kill_i   = 1'b0;
        bus.funct3_i = '0;
        bus.op_a_i   = '0;
        bus.op_b_i   = '0;
        reset        = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset busy", 64'(bus.busy_o), 64'(0));
        check("reset done", 64'(bus.done_o), 64'(0));
        check("reset result", 64'(bus.result_o), 64'(0));

        // Directed vectors.
        vecs.push_back(vec_t'{FUNCT3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_NORM});
        vecs.push_back(vec_t'{FUNCT3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_NORM});
        vecs.push_back(vec_t'{FUNCT3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, LAT_NORM});
        vecs.push_back(vec_t'{FUNCT3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_NORM});
        vecs.push_back(vec_t'{FUNCT3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, LAT_NORM});
        vecs.push_back(vec_t'{FUNCT3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, LAT_NORM});
        vecs.push_back(vec_t'{FUNCT3_DIVU,   32'd100,        32'd7,         32'd14,        LAT_NORM});
        vecs.push_back(vec_t'{FUNCT3_REMU,   32'd100,        32'd7,         32'd2,         LAT_NORM});
        vecs.push_back(vec_t'{FUNCT3_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, LAT_SPEC});
        vecs.push_back(vec_t'{FUNCT3_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, LAT_SPEC});
        vecs.push_back(vec_t'{FUNCT3_REMU,   32'd5,          32'd0,         32'd5,         LAT_SPEC});
        vecs.push_back(vec_t'{FUNCT3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, LAT_SPEC});
        vecs.push_back(vec_t'{FUNCT3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, LAT_SPEC});
        vecs.push_back(vec_t'{FUNCT3_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, LAT_NORM});
        vecs.push_back(vec_t'{FUNCT3_MUL,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, LAT_NORM});
        foreach (vecs[i]) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b,
                          vecs[i].exp, vecs[i].lat);
        end

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom);
            a = pick_operand();
            b = pick_operand();
            run_and_check($sformatf("rnd%0d f=%0d a=%h b=%h", i, f, a, b), f, a, b,
                          ref_model(f, a, b), ref_latency(f, a, b));
        end

        // Kill mid-CALC: busy drops, no done, result keeps its previous value.
        run_and_check("pre-kill", FUNCT3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_NORM);
        @(negedge clk);
        bus.funct3_i = FUNCT3_DIVU;
        bus.op_a_i   = 32'd100;
        bus.op_b_i   = 32'd7;
        bus.start_i  = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (10) @(negedge clk);
        bus.kill_i = 1'b1;
        @(negedge clk);
        bus.kill_i = 1'b0;
        check("kill busy", 64'(bus.busy_o), 64'(0));
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done_o) dones++;
        end
        check("kill no done", 64'(dones), 64'(0));
        check("kill result held", 64'(bus.result_o), 64'(32'hFFFF_FFEB));

        // Kill together with start in IDLE: nothing accepted.
        bus.funct3_i = FUNCT3_MUL;
        bus.start_i  = 1'b1;
        bus.kill_i   = 1'b1;
        @(negedge clk);
        bus.start_i  = 1'b0;
        bus.kill_i   = 1'b0;
        check("kill+start busy", 64'(bus.busy_o), 64'(0));
        @(negedge clk);
        check("kill+start busy2", 64'(bus.busy_o), 64'(0));

        // Reset mid-CALC: every output returns to zero.
        bus.funct3_i = FUNCT3_DIVU;
        bus.op_a_i   = 32'd100;
        bus.op_b_i   = 32'd7;
        bus.start_i  = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid reset busy", 64'(bus.busy_o), 64'(0));
        check("mid reset done", 64'(bus.done_o), 64'(0));
        check("mid reset result", 64'(bus.result_o), 64'(0));

        // Second start during CALC is ignored: exactly one done, first result.
        @(negedge clk);
        bus.funct3_i = FUNCT3_MUL;
        bus.op_a_i   = 32'd7;
        bus.op_b_i   = 32'hFFFF_FFFD;
        bus.start_i  = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        dones = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 5) begin
                bus.funct3_i = FUNCT3_DIVU;
                bus.op_a_i   = 32'd100;
                bus.op_b_i   = 32'd7;
                bus.start_i  = 1'b1;
            end else begin
                bus.start_i  = 1'b0;
            end
            if (bus.done_o) dones++;
        end
        check("double start dones", 64'(dones), 64'(1));
        check("double start result", 64'(bus.result_o), 64'(32'hFFFF_FFEB));

        // Back-to-back: the second start lands in the IDLE cycle after DONE.
        run_and_check("b2b first", FUNCT3_REMU, 32'd100, 32'd7, 32'd2, LAT_NORM);
        run_and_check("b2b second", FUNCT3_DIVU, 32'd100, 32'd7, 32'd14, LAT_NORM);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
